// File: rtl/lenet_digit_classifier.sv
// ---------------------------------------------------------------------------
// lenet_digit_classifier
//
// Single-frame digit classifier. On a go pulse the block streams a 32x32
// frame out of the source ROM and sums each 4x4 pixel block into one of 64
// features. It then scores 10 classes with a fully connected layer whose
// signed weights come from the weight ROM, and reports the arg-max class.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   go                 start pulse, only honoured in IDLE
//   cena_src, aa_src   source ROM enable (active low) and raster address
//   qa_src             source ROM pixel, valid one cycle after the address
//   cena_w, aa_w       weight ROM enable (active low), class*64 + feature
//   qa_w               signed weight, valid one cycle after the address
//   digit              winning class, held until the next result
//   ready              one-cycle pulse, digit valid in the same cycle
// ---------------------------------------------------------------------------
module lenet_digit_classifier #(
    parameter int WD = 8,
    parameter int WW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          go,
    output logic          cena_src,
    output logic [9:0]    aa_src,
    input  logic [WD:0]   qa_src,
    output logic          cena_w,
    output logic [9:0]    aa_w,
    input  logic [WW-1:0] qa_w,
    output logic [3:0]    digit,
    output logic          ready
);

    // A feature holds the sum of 16 pixels; the product of a signed weight
    // and a zero-extended feature needs one extra sign bit.
    localparam int FW = WD + 5;
    localparam int PW = WW + FW + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FETCH_DRAIN,
        MAC,
        MAC_DRAIN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         aa_src_q, aa_src_d;
    logic [9:0]         aa_w_q, aa_w_d;
    logic [FW-1:0]      feat_q [64];
    logic [FW-1:0]      feat_d [64];
    logic               rd_vld_q, rd_vld_d;
    logic [5:0]         rd_feat_q, rd_feat_d;
    logic               w_vld_q, w_vld_d;
    logic [5:0]         w_feat_q, w_feat_d;
    logic [3:0]         w_cls_q, w_cls_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] best_score_q, best_score_d;
    logic [3:0]         best_idx_q, best_idx_d;
    logic [3:0]         digit_q, digit_d;
    logic               ready_q, ready_d;

    logic signed [PW-1:0] w_ext;
    logic signed [PW-1:0] f_ext;
    logic signed [PW-1:0] prod;
    logic signed [31:0]   score_new;

    assign cena_src = (state_q != FETCH);
    assign cena_w   = (state_q != MAC);
    assign aa_src   = aa_src_q;
    assign aa_w     = aa_w_q;
    assign digit    = digit_q;
    assign ready    = ready_q;

    // Datapath and FSM next-state. The ROM data arrives one cycle after its
    // address, so the feature index / class of each outstanding read is
    // pipelined alongside it. Weights arrive class by class in address order,
    // so a single accumulator suffices: it restarts at feature 0 of every
    // class, and the finished score is folded into the running arg-max when
    // feature 63 lands. The last class lands on the MAC_DRAIN edge, so the
    // next-value of the arg-max is already final when digit is loaded.
    always_comb begin
        state_d      = state_q;
        aa_src_d     = aa_src_q;
        aa_w_d       = aa_w_q;
        feat_d       = feat_q;
        acc_d        = acc_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        digit_d      = digit_q;
        ready_d      = 1'b0;

        rd_vld_d  = (state_q == FETCH);
        rd_feat_d = {aa_src_q[9:7], aa_src_q[4:2]};
        w_vld_d   = (state_q == MAC);
        w_feat_d  = aa_w_q[5:0];
        w_cls_d   = aa_w_q[9:6];

        w_ext     = PW'($signed(qa_w));
        f_ext     = PW'({1'b0, feat_q[w_feat_q]});
        prod      = w_ext * f_ext;
        score_new = ((w_feat_q == 6'd0) ? 32'sd0 : acc_q) + 32'(prod);

        if (rd_vld_q) begin
            feat_d[rd_feat_q] = feat_q[rd_feat_q] + FW'(qa_src);
        end

        if (w_vld_q) begin
            acc_d = score_new;
            // Strictly-greater keeps the lowest index on ties.
            if (w_feat_q == 6'd63 && (w_cls_q == 4'd0 || score_new > best_score_q)) begin
                best_idx_d   = w_cls_q;
                best_score_d = score_new;
            end
        end

        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d      = FETCH;
                    aa_src_d     = '0;
                    aa_w_d       = '0;
                    acc_d        = '0;
                    best_score_d = '0;
                    best_idx_d   = '0;
                    for (int i = 0; i < 64; i++) begin
                        feat_d[i] = '0;
                    end
                end
            end
            FETCH: begin
                aa_src_d = aa_src_q + 10'd1;
                if (aa_src_q == 10'd1023) begin
                    state_d = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                state_d = MAC;
            end
            MAC: begin
                if (aa_w_q == 10'd639) begin
                    aa_w_d  = '0;
                    state_d = MAC_DRAIN;
                end else begin
                    aa_w_d = aa_w_q + 10'd1;
                end
            end
            MAC_DRAIN: begin
                state_d = DONE;
                ready_d = 1'b1;
                digit_d = best_idx_d;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            aa_src_q     <= '0;
            aa_w_q       <= '0;
            for (int i = 0; i < 64; i++) begin
                feat_q[i] <= '0;
            end
            rd_vld_q     <= 1'b0;
            rd_feat_q    <= '0;
            w_vld_q      <= 1'b0;
            w_feat_q     <= '0;
            w_cls_q      <= '0;
            acc_q        <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            digit_q      <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            aa_src_q     <= aa_src_d;
            aa_w_q       <= aa_w_d;
            feat_q       <= feat_d;
            rd_vld_q     <= rd_vld_d;
            rd_feat_q    <= rd_feat_d;
            w_vld_q      <= w_vld_d;
            w_feat_q     <= w_feat_d;
            w_cls_q      <= w_cls_d;
            acc_q        <= acc_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            digit_q      <= digit_d;
            ready_q      <= ready_d;
        end
    end

endmodule

// File: tb/tb_lenet_digit_classifier.sv
// ---------------------------------------------------------------------------
// tb_lenet_digit_classifier
//
// Self-checking bench for lenet_digit_classifier. Registered ROM models feed
// the DUT from src_mem / w_mem; a behavioural model computes the expected
// digit from the same memories with plain nested loops.
// ---------------------------------------------------------------------------
module tb_lenet_digit_classifier;

    logic        clk;
    logic        rstn;
    logic        go;
    logic        cena_src;
    logic [9:0]  aa_src;
    logic [8:0]  qa_src;
    logic        cena_w;
    logic [9:0]  aa_w;
    logic [7:0]  qa_w;
    logic [3:0]  digit;
    logic        ready;

    logic [8:0]        src_mem [1024];
    logic signed [7:0] w_mem   [640];

    int n_checks;
    int n_fails;

    lenet_digit_classifier #(.WD(8), .WW(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .go       (go),
        .cena_src (cena_src),
        .aa_src   (aa_src),
        .qa_src   (qa_src),
        .cena_w   (cena_w),
        .aa_w     (aa_w),
        .qa_w     (qa_w),
        .digit    (digit),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROMs: data appears one cycle after an enabled address.
    always @(posedge clk) begin
        if (!cena_src) qa_src <= src_mem[aa_src];
        if (!cena_w)   qa_w   <= w_mem[aa_w];
    end

    // Reference: 4x4 block sums, dot product per class, first strict maximum.
    function automatic logic [3:0] model_digit();
        longint feat [64];
        longint score;
        longint best_score;
        logic [3:0] best;
        for (int i = 0; i < 64; i++) feat[i] = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                feat[(r / 4) * 8 + (c / 4)] += longint'(src_mem[r * 32 + c]);
        best = 4'd0;
        best_score = 0;
        for (int k = 0; k < 10; k++) begin
            score = 0;
            for (int f = 0; f < 64; f++)
                score += longint'(w_mem[k * 64 + f]) * feat[f];
            if (k == 0 || score > best_score) begin
                best = 4'(k);
                best_score = score;
            end
        end
        return best;
    endfunction

    task automatic fill_image_const(input int v);
        for (int i = 0; i < 1024; i++) src_mem[i] = 9'(v);
    endtask

    task automatic fill_image_random();
        for (int i = 0; i < 1024; i++) src_mem[i] = 9'($urandom_range(0, 511));
    endtask

    task automatic fill_weights_per_class(input int w0, input int w1, input int w2,
                                          input int w3, input int w4, input int w5,
                                          input int w6, input int w7, input int w8,
                                          input int w9);
        int wv [10];
        wv = '{w0, w1, w2, w3, w4, w5, w6, w7, w8, w9};
        for (int k = 0; k < 10; k++)
            for (int f = 0; f < 64; f++) w_mem[k * 64 + f] = 8'(wv[k]);
    endtask

    task automatic fill_weights_random();
        for (int i = 0; i < 640; i++) w_mem[i] = 8'($urandom_range(0, 255));
    endtask

    // Runs one frame and records what the DUT did; the calling test compares.
    // Cycle k is the k-th negedge after the go-sampling edge. extra_k > 0
    // raises go again for one cycle starting at cycle extra_k.
    task automatic run_frame(input int extra_k, output int lat, output logic [3:0] dig,
                             output int src_errs, output int w_errs, output int readies);
        lat = 0;
        dig = 4'd0;
        src_errs = 0;
        w_errs = 0;
        readies = 0;
        @(negedge clk);
        go = 1'b1;
        for (int k = 1; k <= 1675; k++) begin
            @(negedge clk);
            if (k == 1) go = 1'b0;
            if (extra_k > 0 && k == extra_k) go = 1'b1;
            if (extra_k > 0 && k == extra_k + 1) go = 1'b0;
            if (k <= 1024) begin
                if (cena_src !== 1'b0 || aa_src !== 10'(k - 1)) src_errs++;
            end else if (cena_src !== 1'b1) begin
                src_errs++;
            end
            if (k >= 1026 && k <= 1665) begin
                if (cena_w !== 1'b0 || aa_w !== 10'(k - 1026)) w_errs++;
            end else if (cena_w !== 1'b1) begin
                w_errs++;
            end
            if (ready === 1'b1) begin
                readies++;
                if (lat == 0) begin
                    lat = k;
                    dig = digit;
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        go = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            go = ~go;
            n_checks++;
            if (ready !== 1'b0 || digit !== 4'd0 || cena_src !== 1'b1 || cena_w !== 1'b1 ||
                aa_src !== 10'd0 || aa_w !== 10'd0) begin
                n_fails++;
                $display("[TB] FAIL reset_hold: ready=%b digit=%0d cena_src=%b cena_w=%b aa_src=%0d aa_w=%0d, required 0 0 1 1 0 0",
                         ready, digit, cena_src, cena_w, aa_src, aa_w);
            end
        end
        go = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b0 || cena_src !== 1'b1 || cena_w !== 1'b1) begin
                n_fails++;
                $display("[TB] FAIL reset_release: ready=%b cena_src=%b cena_w=%b, required 0 1 1",
                         ready, cena_src, cena_w);
            end
        end
    endtask

    task automatic test_sequencing();
        int lat, se, we, nr;
        logic [3:0] d, exp_d;
        fill_image_random();
        fill_weights_random();
        exp_d = model_digit();
        run_frame(0, lat, d, se, we, nr);
        n_checks++;
        if (se !== 0) begin n_fails++; $display("[TB] FAIL src_sequence: %0d bad cycles, required 0", se); end
        n_checks++;
        if (we !== 0) begin n_fails++; $display("[TB] FAIL w_sequence: %0d bad cycles, required 0", we); end
        n_checks++;
        if (nr !== 1) begin n_fails++; $display("[TB] FAIL ready_count: %0d, required 1", nr); end
        n_checks++;
        if (lat !== 1667) begin n_fails++; $display("[TB] FAIL latency: %0d, required 1667", lat); end
        n_checks++;
        if (d !== exp_d) begin n_fails++; $display("[TB] FAIL seq_digit: %0d, required %0d", d, exp_d); end
    endtask

    task automatic test_all255();
        int lat, se, we, nr;
        logic [3:0] d;
        fill_image_const(255);
        fill_weights_per_class(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_frame(0, lat, d, se, we, nr);
        n_checks++;
        if (d !== 4'd3 || nr !== 1) begin
            n_fails++;
            $display("[TB] FAIL all255_digit: digit=%0d readies=%0d, required 3 1", d, nr);
        end
    endtask

    task automatic test_ties_negative();
        int lat, se, we, nr;
        logic [3:0] d;
        fill_image_const(0);
        fill_weights_random();
        run_frame(0, lat, d, se, we, nr);
        n_checks++;
        if (d !== 4'd0) begin n_fails++; $display("[TB] FAIL zero_image: %0d, required 0", d); end

        fill_image_const(1);
        fill_weights_per_class(-1, -1, 2, -1, -1, 2, -1, -1, -1, -1);
        run_frame(0, lat, d, se, we, nr);
        n_checks++;
        if (d !== 4'd2) begin n_fails++; $display("[TB] FAIL tie_lowest: %0d, required 2", d); end

        fill_weights_per_class(-1, -1, -1, -1, -1, -1, -1, -1, -1, 0);
        run_frame(0, lat, d, se, we, nr);
        n_checks++;
        if (d !== 4'd9) begin n_fails++; $display("[TB] FAIL negative_scores: %0d, required 9", d); end
    endtask

    task automatic test_random_frames();
        int lat, se, we, nr;
        logic [3:0] d, exp_d;
        for (int t = 0; t < 3; t++) begin
            fill_image_random();
            fill_weights_random();
            exp_d = model_digit();
            run_frame(0, lat, d, se, we, nr);
            n_checks++;
            if (d !== exp_d || lat !== 1667) begin
                n_fails++;
                $display("[TB] FAIL random_frame%0d: digit=%0d lat=%0d, required %0d 1667", t, d, lat, exp_d);
            end
        end
    endtask

    task automatic test_busy_go();
        int lat, se, we, nr;
        logic [3:0] d, exp_d;
        fill_image_random();
        fill_weights_random();
        exp_d = model_digit();
        run_frame(500, lat, d, se, we, nr);
        n_checks++;
        if (nr !== 1 || lat !== 1667 || se !== 0 || we !== 0) begin
            n_fails++;
            $display("[TB] FAIL busy_go: readies=%0d lat=%0d seq_errs=%0d/%0d, required 1 1667 0/0", nr, lat, se, we);
        end
        n_checks++;
        if (d !== exp_d) begin n_fails++; $display("[TB] FAIL busy_digit: %0d, required %0d", d, exp_d); end
    endtask

    task automatic test_back_to_back();
        int lat, se, we, nr;
        logic [3:0] d, exp_d;
        // First frame also raises go during its DONE cycle, which must not start a frame.
        fill_image_const(255);
        fill_weights_per_class(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        exp_d = model_digit();
        run_frame(1667, lat, d, se, we, nr);
        n_checks++;
        if (d !== exp_d || nr !== 1 || se !== 0 || we !== 0) begin
            n_fails++;
            $display("[TB] FAIL b2b_first: digit=%0d readies=%0d seq_errs=%0d/%0d, required %0d 1 0/0", d, nr, se, we, exp_d);
        end
        fill_image_random();
        fill_weights_random();
        exp_d = model_digit();
        run_frame(0, lat, d, se, we, nr);
        n_checks++;
        if (d !== exp_d || lat !== 1667) begin
            n_fails++;
            $display("[TB] FAIL b2b_second: digit=%0d lat=%0d, required %0d 1667", d, lat, exp_d);
        end
    endtask

    task automatic test_reset_mid_mac();
        int lat, se, we, nr, stray;
        logic [3:0] d, exp_d;
        fill_image_random();
        fill_weights_random();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (1300) @(negedge clk);
        n_checks++;
        if (cena_w !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_mac_active: cena_w=%b, required 0", cena_w); end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || digit !== 4'd0 || cena_src !== 1'b1 || cena_w !== 1'b1 ||
            aa_src !== 10'd0 || aa_w !== 10'd0) begin
            n_fails++;
            $display("[TB] FAIL abort_outputs: ready=%b digit=%0d cena_src=%b cena_w=%b aa_src=%0d aa_w=%0d, required 0 0 1 1 0 0",
                     ready, digit, cena_src, cena_w, aa_src, aa_w);
        end
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready !== 1'b0) stray++;
        end
        rstn = 1'b1;
        repeat (400) begin
            @(negedge clk);
            if (ready !== 1'b0 || cena_w !== 1'b1) stray++;
        end
        n_checks++;
        if (stray !== 0) begin n_fails++; $display("[TB] FAIL abort_no_ready: %0d bad cycles, required 0", stray); end
        fill_image_random();
        exp_d = model_digit();
        run_frame(0, lat, d, se, we, nr);
        n_checks++;
        if (d !== exp_d || lat !== 1667 || nr !== 1) begin
            n_fails++;
            $display("[TB] FAIL after_abort: digit=%0d lat=%0d readies=%0d, required %0d 1667 1", d, lat, nr, exp_d);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails = 0;
        rstn = 1'b0;
        go = 1'b0;
        fill_image_const(0);
        fill_weights_per_class(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("[TB] starting lenet_digit_classifier bench");
        test_reset();
        test_sequencing();
        test_all255();
        test_ties_negative();
        test_random_frames();
        test_busy_go();
        test_back_to_back();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
